// File: rtl/fm_param_loader.sv
// fm_param_loader
// Host-facing control stage for fm_generator. A serial write frame
// (8-bit address, 32-bit data, MSB first) updates shadow copies of the
// FM tuning words. A commit write copies every shadow into the active
// outputs at once and pulses o_update in that same cycle.
//
// Ports
//   i_ref_clk              system clock
//   i_resetb               asynchronous active-low reset
//   i_sck, i_cs_n, i_mosi  asynchronous serial interface, synchronized here
//   o_carrier_increment    active carrier centre increment (ACC_W-1 bits)
//   o_modulation_increment active modulation increment (ACC_W-1 bits)
//   o_deviation            active deviation (DEV_W bits)
//   o_ce                   generator clock enable
//   o_update               one-cycle pulse when the active words are loaded
//   o_frame_err            one-cycle pulse when a frame is rejected
//   o_err_count            saturating count of rejected frames
//   o_miso                 read data, present only with FM_PARAM_READBACK_EN
//
// Build option: define FM_PARAM_READBACK_EN to add the o_miso read-back
// path. An address with bit7 set then reads the active word at addr[6:0].
module fm_param_loader #(
  parameter int ACC_W       = 32,
  parameter int DEV_W       = 17,
  parameter int RST_CARRIER = 200000000,
  parameter int RST_MOD     = 66770,
  parameter int RST_DEV     = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 i_ref_clk,
  input  logic                 i_resetb,
  input  logic                 i_sck,
  input  logic                 i_cs_n,
  input  logic                 i_mosi,
  output logic [ACC_W-2:0]     o_carrier_increment,
  output logic [ACC_W-2:0]     o_modulation_increment,
  output logic [DEV_W-1:0]     o_deviation,
  output logic                 o_ce,
  output logic                 o_update,
  output logic                 o_frame_err,
  output logic [ERR_CNT_W-1:0] o_err_count
`ifdef FM_PARAM_READBACK_EN
  ,
  output logic                 o_miso
`endif
);

  localparam logic [ACC_W-2:0] RST_CAR_V = (ACC_W-1)'(RST_CARRIER);
  localparam logic [ACC_W-2:0] RST_MOD_V = (ACC_W-1)'(RST_MOD);
  localparam logic [DEV_W-1:0] RST_DEV_V = DEV_W'(RST_DEV);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t state_q, state_d;

  logic [1:0] sckSync_q, csSync_q, mosiSync_q;
  logic       sckPrev_q;
  logic [1:0] settle_q;
  logic       idleHigh_q, idleHigh_d;

  logic [5:0]           bitCnt_q, bitCnt_d;
  // Only the low ACC_W-1 data bits are ever used, so older bits simply
  // fall off the top; the address is captured separately on bit 8.
  logic [ACC_W-2:0]     shift_q, shift_d;
  logic [7:0]           addr_q, addr_d;
  logic [ACC_W-2:0]     carShadow_q, carShadow_d, modShadow_q, modShadow_d;
  logic [DEV_W-1:0]     devShadow_q, devShadow_d;
  logic [ACC_W-2:0]     carrier_q, carrier_d, modulation_q, modulation_d;
  logic [DEV_W-1:0]     deviation_q, deviation_d;
  logic                 ce_q, ce_d, update_q, update_d;
  logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;
  logic                 frameErr, writeFrame;

  logic sckRise, sckFall, csLevel, mosiBit;

  assign sckRise = sckSync_q[1] & ~sckPrev_q;
  assign sckFall = ~sckSync_q[1] & sckPrev_q;
  assign csLevel = csSync_q[1];
  assign mosiBit = mosiSync_q[1];

`ifdef FM_PARAM_READBACK_EN
  assign writeFrame = ~addr_q[7];
`else
  assign writeFrame = 1'b1;
`endif

  // Two-flop synchronizers plus the sck edge history. settle_q marks when
  // the cs_n synchronizer output reflects the real pin rather than its reset
  // value, so a cs_n held low through reset is not mistaken for a new frame.
  always_ff @(posedge i_ref_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      sckSync_q  <= 2'b00;
      csSync_q   <= 2'b11;
      mosiSync_q <= 2'b00;
      sckPrev_q  <= 1'b0;
      settle_q   <= 2'b00;
    end else begin
      sckSync_q  <= {sckSync_q[0], i_sck};
      csSync_q   <= {csSync_q[0], i_cs_n};
      mosiSync_q <= {mosiSync_q[0], i_mosi};
      sckPrev_q  <= sckSync_q[1];
      settle_q   <= {settle_q[0], 1'b1};
    end
  end

  // Frame FSM, shadow/active registers and error accounting.
  // A frame only starts after cs_n has been seen genuinely high (idleHigh).
  always_comb begin
    state_d      = state_q;
    idleHigh_d   = idleHigh_q;
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    carShadow_d  = carShadow_q;
    modShadow_d  = modShadow_q;
    devShadow_d  = devShadow_q;
    carrier_d    = carrier_q;
    modulation_d = modulation_q;
    deviation_d  = deviation_q;
    ce_d         = ce_q;
    update_d     = 1'b0;
    errCnt_d     = errCnt_q;
    frameErr     = 1'b0;

    if (settle_q[1] && csLevel) idleHigh_d = 1'b1;

    case (state_q)
      IDLE: begin
        bitCnt_d = '0;
        if (idleHigh_q && !csLevel) begin
          state_d    = SHIFT;
          idleHigh_d = 1'b0;
        end
      end
      SHIFT: begin
        if (sckRise) begin
          shift_d = {shift_q[ACC_W-3:0], mosiBit};
          if (bitCnt_q == 6'd7) addr_d = {shift_q[6:0], mosiBit};
          if (bitCnt_q != 6'd41) bitCnt_d = bitCnt_q + 6'd1;
        end
        if (csLevel) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (bitCnt_q == 6'd40) begin
          if (writeFrame) begin
            case (addr_q)
              8'h00: carShadow_d = shift_q;
              8'h01: modShadow_d = shift_q;
              8'h02: devShadow_d = shift_q[DEV_W-1:0];
              8'h03: begin
                ce_d = shift_q[0];
                if (shift_q[1]) begin
                  carrier_d    = carShadow_q;
                  modulation_d = modShadow_q;
                  deviation_d  = devShadow_q;
                  update_d     = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end else begin
          frameErr = 1'b1;
          if (errCnt_q != '1) errCnt_d = errCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      state_q      <= IDLE;
      idleHigh_q   <= 1'b0;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      carShadow_q  <= RST_CAR_V;
      modShadow_q  <= RST_MOD_V;
      devShadow_q  <= RST_DEV_V;
      carrier_q    <= RST_CAR_V;
      modulation_q <= RST_MOD_V;
      deviation_q  <= RST_DEV_V;
      ce_q         <= 1'b0;
      update_q     <= 1'b0;
      errCnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      idleHigh_q   <= idleHigh_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      carShadow_q  <= carShadow_d;
      modShadow_q  <= modShadow_d;
      devShadow_q  <= devShadow_d;
      carrier_q    <= carrier_d;
      modulation_q <= modulation_d;
      deviation_q  <= deviation_d;
      ce_q         <= ce_d;
      update_q     <= update_d;
      errCnt_q     <= errCnt_d;
    end
  end

  assign o_carrier_increment    = carrier_q;
  assign o_modulation_increment = modulation_q;
  assign o_deviation            = deviation_q;
  assign o_ce                   = ce_q;
  assign o_update               = update_q;
  assign o_frame_err            = frameErr;
  assign o_err_count            = errCnt_q;

`ifdef FM_PARAM_READBACK_EN
  logic [31:0] readWord, readShift_q, readShift_d;
  logic        readActive_q, readActive_d;

  // The read word is loaded on the sck fall after the 8th address bit so
  // the host sees data bit 31 before its 9th rising edge; each later fall
  // moves the next bit up. The output is forced low outside the data phase.
  always_comb begin
    readWord     = '0;
    readShift_d  = readShift_q;
    readActive_d = readActive_q;
    case (addr_q[6:0])
      7'h00:   readWord = 32'(carrier_q);
      7'h01:   readWord = 32'(modulation_q);
      7'h02:   readWord = 32'(deviation_q);
      7'h03:   readWord = 32'(ce_q);
      default: readWord = '0;
    endcase
    if (state_q != SHIFT) begin
      readActive_d = 1'b0;
    end else if (sckFall) begin
      if (bitCnt_q == 6'd8 && addr_q[7]) begin
        readShift_d  = readWord;
        readActive_d = 1'b1;
      end else if (bitCnt_q >= 6'd40) begin
        readActive_d = 1'b0;
      end else begin
        readShift_d = {readShift_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      readShift_q  <= '0;
      readActive_q <= 1'b0;
    end else begin
      readShift_q  <= readShift_d;
      readActive_q <= readActive_d;
    end
  end

  assign o_miso = readActive_q & readShift_q[31];
`endif

endmodule

// File: tb/tb_fm_param_loader.sv
// Testbench for fm_param_loader. Serial frames are driven from tasks;
// expected active words and error counts are queued as each frame is sent
// and compared by a monitor when o_update or o_frame_err pulses.
module tb_fm_param_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetb, sck, csN, mosi, miso;
  logic [30:0] carOut, modOut;
  logic [16:0] devOut;
  logic        ceOut, updOut, ferrOut;
  logic [7:0]  errCntOut;

  fm_param_loader dut (
    .i_ref_clk              (clk),
    .i_resetb               (resetb),
    .i_sck                  (sck),
    .i_cs_n                 (csN),
    .i_mosi                 (mosi),
    .o_carrier_increment    (carOut),
    .o_modulation_increment (modOut),
    .o_deviation            (devOut),
    .o_ce                   (ceOut),
    .o_update               (updOut),
    .o_frame_err            (ferrOut),
    .o_err_count            (errCntOut)
`ifdef FM_PARAM_READBACK_EN
    ,
    .o_miso                 (miso)
`endif
  );

`ifndef FM_PARAM_READBACK_EN
  assign miso = 1'b0;
`endif

  typedef struct packed {
    logic [30:0] car;
    logic [30:0] mod;
    logic [16:0] dev;
    logic        ce;
  } active_t;

  active_t    updQ[$];
  logic [7:0] errQ[$];
  int checkCount = 0;
  int errorCount = 0;
  int nBad = 0;

  // Bench model of shadow and active state
  logic [30:0] sCar, sMod, mCar, mMod;
  logic [16:0] sDev, mDev;
  logic        mCe;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic modelReset();
    sCar = 31'd200000000; sMod = 31'd66770; sDev = 17'd4;
    mCar = sCar;          mMod = sMod;      mDev = sDev;
    mCe  = 1'b0;
    nBad = 0;
  endtask

  task automatic checkActive(input string tag);
    checkOutput({tag, ".carrier"},    64'(carOut), 64'(mCar));
    checkOutput({tag, ".modulation"}, 64'(modOut), 64'(mMod));
    checkOutput({tag, ".deviation"},  64'(devOut), 64'(mDev));
    checkOutput({tag, ".ce"},         64'(ceOut),  64'(mCe));
  endtask

  task automatic shiftBits(input logic [63:0] w, input int hi, input int lo,
                           input int total, inout logic [31:0] rd);
    for (int i = hi; i >= lo; i--) begin
      mosi = w[i];
      waitCycles(6);
      if (total - 1 - i >= 8) rd = {rd[30:0], miso};
      sck = 1'b1;
      waitCycles(6);
      sck = 1'b0;
    end
  endtask

  task automatic sendFrame(input logic [63:0] w, input int nbits,
                           output logic [31:0] rd);
    logic [31:0] r;
    r = '0;
    csN = 1'b0;
    waitCycles(4);
    if (nbits > 0) shiftBits(w, nbits - 1, 0, nbits, r);
    waitCycles(4);
    csN = 1'b1;
    waitCycles(10);
    rd = r;
  endtask

  // One register write, with the model updated and any commit queued
  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    case (a)
      8'h00: sCar = d[30:0];
      8'h01: sMod = d[30:0];
      8'h02: sDev = d[16:0];
      8'h03: begin
        mCe = d[0];
        if (d[1]) begin
          mCar = sCar; mMod = sMod; mDev = sDev;
          updQ.push_back('{car: mCar, mod: mMod, dev: mDev, ce: mCe});
        end
      end
      default: ;
    endcase
    sendFrame({24'h0, a, d}, 40, rd);
  endtask

  task automatic sendBadFrame(input int nbits);
    logic [31:0] rd;
    nBad++;
    errQ.push_back(nBad > 255 ? 8'd255 : 8'(nBad));
    sendFrame(64'hA5A5_1234_5678_9ABC, nbits, rd);
  endtask

  // Monitor: pops expectations when the DUT reports an update or an error
  initial begin
    active_t    e;
    logic [7:0] ec;
    forever begin
      @(negedge clk);
      if (resetb && updOut) begin
        if (updQ.size() == 0) begin
          checkOutput("unexpected_update", 64'd1, 64'd0);
        end else begin
          e = updQ.pop_front();
          checkOutput("upd.carrier",    64'(carOut), 64'(e.car));
          checkOutput("upd.modulation", 64'(modOut), 64'(e.mod));
          checkOutput("upd.deviation",  64'(devOut), 64'(e.dev));
          checkOutput("upd.ce",         64'(ceOut),  64'(e.ce));
        end
        @(negedge clk);
        checkOutput("update_one_cycle", 64'(updOut), 64'd0);
      end else if (resetb && ferrOut) begin
        if (errQ.size() == 0) begin
          checkOutput("unexpected_frame_err", 64'd1, 64'd0);
        end else begin
          ec = errQ.pop_front();
          @(negedge clk);
          checkOutput("err_count", 64'(errCntOut), 64'(ec));
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic [63:0] midFrame;
    resetb = 1'b0; sck = 1'b0; csN = 1'b1; mosi = 1'b0;
    modelReset();
    waitCycles(5);
    resetb = 1'b1;
    waitCycles(3);

    checkActive("reset");
    checkOutput("reset.update",    64'(updOut),    64'd0);
    checkOutput("reset.err_count", 64'(errCntOut), 64'd0);

    // Shadow writes leave the active words alone until commit
    applyStimulus(8'h00, 32'd50000000);
    applyStimulus(8'h01, 32'd10000000);
    checkActive("shadow_only");
    applyStimulus(8'h03, 32'h3);
    checkActive("after_commit");

    // Truncation of over-wide data
    applyStimulus(8'h02, 32'hFFFF_FFFF);
    applyStimulus(8'h03, 32'h3);
    applyStimulus(8'h00, 32'hFFFF_FFFF);
    applyStimulus(8'h03, 32'h3);
    checkOutput("trunc.carrier",   64'(carOut), 64'h7FFF_FFFF);
    checkOutput("trunc.deviation", 64'(devOut), 64'h1FFFF);

    // Commit with no shadow change, then an unmapped address
    applyStimulus(8'h03, 32'h3);
    applyStimulus(8'h10, 32'h1234_5678);
    checkActive("unmapped");

    // Framing errors: short, long and empty frames
    sendBadFrame(39);
    sendBadFrame(41);
    sendBadFrame(0);
    checkOutput("three_errors", 64'(errCntOut), 64'd3);
    checkActive("after_errors");
    for (int i = 0; i < 297; i++) sendBadFrame(0);
    checkOutput("err_saturated", 64'(errCntOut), 64'd255);

    // Reset in the middle of a frame, then finish shifting the bits
    midFrame = {24'h0, 8'h00, 32'h0000_1111};
    rd = '0;
    csN = 1'b0;
    waitCycles(4);
    shiftBits(midFrame, 39, 20, 40, rd);
    resetb = 1'b0;
    modelReset();
    waitCycles(3);
    resetb = 1'b1;
    shiftBits(midFrame, 19, 0, 40, rd);
    waitCycles(4);
    csN = 1'b1;
    waitCycles(10);
    checkActive("mid_reset");
    checkOutput("mid_reset.err_count", 64'(errCntOut), 64'd0);

    applyStimulus(8'h01, 32'd1234);
    applyStimulus(8'h03, 32'h2);
    checkActive("post_reset_frame");

`ifdef FM_PARAM_READBACK_EN
    applyStimulus(8'h00, 32'h1234_5678);
    applyStimulus(8'h03, 32'h2);
    sendFrame({24'h0, 8'h80, 32'h0}, 40, rd);
    checkOutput("readback", 64'(rd), 64'h1234_5678);
    checkActive("after_read");
`endif

    waitCycles(20);
    checkOutput("pending_updates", 64'(updQ.size()), 64'd0);
    checkOutput("pending_errors",  64'(errQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
